multi_debounce_filter: RTL and testbench
========================================

// Module: multi_debounce_filter
// PURPOSE
//  N-channel glitch filter for slow, noisy digital inputs (motor OSC/encoder index, limit switches).
//  Each channel is synchronised, then sampled on a shared prescaled tick.
//  A level change is accepted only after cfg_confirm consecutive agreeing samples.
//  Sits between the input pins and the motor control / position logic.
// PARAMETERS
//  CH_NUM      4    number of independent channels (>=1)
//  DIV_W       8    prescaler width; sample tick every 2**DIV_W clk
//  CONF_W      4    width of cfg_confirm and of the per-channel confirm counter
//  INIT_LEVEL  0    filtered level and FSM state after reset (all channels)
//  GCNT_W      16   glitch counter width (used only with FILTER_GLITCH_CNT_EN)
// PORTS
//  clk          in   1              system clock
//  rst_n        in   1              asynchronous reset, active-low
//  data_in      in   CH_NUM         raw asynchronous inputs
//  cfg_confirm  in   CONF_W         required consecutive samples; 0 is treated as 1
//  data_out     out  CH_NUM         filtered levels
//  rise_pulse   out  CH_NUM         1-clk pulse when data_out goes 0->1
//  fall_pulse   out  CH_NUM         1-clk pulse when data_out goes 1->0
//  glitch_clr   in   1              synchronous clear of all glitch counters
//  glitch_cnt   out  CH_NUM*GCNT_W  per-channel aborted-transition counts, ch0 in LSBs
// BEHAVIOUR
//  - Reset: sync FFs=INIT_LEVEL; prescaler=0; state=STABLE_HI if INIT_LEVEL else STABLE_LO.
//    Reset values: cnt=0; data_out=INIT_LEVEL; pulses=0; glitch_cnt=0. Mid-operation reset aborts any check.
//  - Sync: 2-FF per channel; s = 2nd stage. Prescaler free-runs; tick=1 for 1 clk when all-ones, then wraps to 0.
//  - Non-tick cycles: state and cnt hold.
//  - On tick, per channel (C = max(cfg_confirm,1), sampled at that tick):
//    STABLE_LO: s=1 -> cnt=1; C==1 ? go STABLE_HI + rise : RISE_CHK. s=0 -> stay.
//    RISE_CHK:  s=1 -> cnt+1; if cnt+1>=C -> STABLE_HI, cnt=0, rise. s=0 -> STABLE_LO, cnt=0, glitch.
//    STABLE_HI: mirror of STABLE_LO with s=0, FALL_CHK, fall.
//    FALL_CHK:  mirror of RISE_CHK; s=1 aborts to STABLE_HI, glitch.
//  - data_out is registered and changes on the clk edge after the confirming tick.
//    rise/fall_pulse are high in that same cycle, one clk wide.
//  - Latency: 2 clk sync + <=2**DIV_W clk to first tick + (C-1)*2**DIV_W clk.
//  - cfg_confirm may change at any time. Lowering it below cnt confirms on the next agreeing tick (>= compare).
//  - cnt saturates at 2**CONF_W-1 and never wraps.
//  - Simultaneous glitch on several channels: each channel counts independently.
//  - glitch_clr and glitch in the same cycle: clear wins; result 0.
// CONFIGURATION
//  - FILTER_GLITCH_CNT_EN defined: one GCNT_W saturating counter per channel.
//    Counter increments on each aborted RISE_CHK/FALL_CHK; glitch_clr zeroes all counters.
//  - Undefined: counters not built; glitch_cnt driven all-zero; glitch_clr ignored. Ports remain.
// STRUCTURE
//  - Package filter_sig_pkg: state encodings STABLE_LO=0, RISE_CHK=1, STABLE_HI=2, FALL_CHK=3 (2-bit).
//  - Sub-module filter_channel: sync + FSM + cnt + pulses + optional glitch counter for one channel.
//    Instantiated CH_NUM times by generate. Prescaler and tick are shared in the top level.
// TESTING
//  1 Reset release, INIT_LEVEL=0, inputs low for 10 ticks -> data_out=0, no pulses, glitch_cnt=0.
//  2 DIV_W=2, cfg_confirm=3, ch0 held high -> data_out[0] rises 2+<=4+8 clk after the edge.
//    rise_pulse[0] is high exactly 1 clk at that edge.
//  3 cfg_confirm=3, ch1 high for 2 ticks then low -> data_out[1] stays 0.
//    glitch_cnt[ch1]=1 (macro on) or 0 (macro off).
//  4 cfg_confirm=0, ch2 toggles every tick -> data_out[2] follows each sample 1 tick late; no glitches counted.
//  5 ch3 in FALL_CHK with cnt=1, rst_n pulsed low mid-check -> all outputs return to INIT_LEVEL/0 immediately.
//  6 glitch_clr asserted on the same clk as a ch0 abort -> glitch_cnt[ch0]=0 next cycle.

Source files
------------

// File: rtl/filter_sig_pkg.sv
// Shared definitions for the multi-channel debounce filter: per-channel
// FSM state encoding.
package filter_sig_pkg;

    // Per-channel filter state. STABLE_* hold a confirmed level, *_CHK count
    // agreeing samples towards a level change.
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        RISE_CHK  = 2'd1,
        STABLE_HI = 2'd2,
        FALL_CHK  = 2'd3
    } filt_state_e;

endpackage

// File: rtl/filter_channel.sv
// One debounce channel: 2-FF synchroniser, confirm FSM with saturating
// sample counter, registered level and edge pulses, optional glitch counter.
// Optional feature macro: FILTER_GLITCH_CNT_EN (builds the glitch counter).
//
// Handshake: none. The shared tick is a one-cycle strobe; the channel only
// advances its FSM on cycles where tick is high.
module filter_channel
    import filter_sig_pkg::*;
#(
    parameter int CONF_W     = 4,
    parameter int INIT_LEVEL = 0,
    parameter int GCNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_in,
    input  logic              tick,
    input  logic [CONF_W-1:0] conf,
    input  logic              glitch_clr,
    output logic              data_out,
    output logic              rise_pulse,
    output logic              fall_pulse,
    output logic [GCNT_W-1:0] glitch_cnt,
    output filt_state_e       state
);

    localparam logic        INIT_BIT   = (INIT_LEVEL != 0);
    localparam filt_state_e INIT_STATE = INIT_BIT ? STABLE_HI : STABLE_LO;
    localparam logic [CONF_W-1:0] CNT_MAX = '1;
    localparam logic [CONF_W-1:0] CONF_ONE = CONF_W'(1);

    logic              sync1;
    logic              sync2;
    filt_state_e       state_next;
    logic [CONF_W-1:0] cnt;
    logic [CONF_W-1:0] cnt_next;
    logic [CONF_W-1:0] cnt_sat;
    logic [CONF_W:0]   cnt_inc;
    logic              level_next;
    logic              rise_next;
    logic              fall_next;
    logic              glitch_evt;
    logic              confirm_now;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= INIT_BIT;
            sync2 <= INIT_BIT;
        end else begin
            sync1 <= data_in;
            sync2 <= sync1;
        end
    end

    // Counter increment is evaluated one bit wider so the >= compare sees
    // the true cnt+1; the stored value saturates instead of wrapping.
    assign cnt_inc     = {1'b0, cnt} + {{CONF_W{1'b0}}, 1'b1};
    assign cnt_sat     = (cnt == CNT_MAX) ? cnt : cnt_inc[CONF_W-1:0];
    assign confirm_now = (cnt_inc >= {1'b0, conf});

    // Next-state logic; only acts on tick cycles, otherwise everything holds.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        level_next = data_out;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        glitch_evt = 1'b0;
        if (tick) begin
            case (state)
                STABLE_LO: begin
                    if (sync2) begin
                        if (conf == CONF_ONE) begin
                            state_next = STABLE_HI;
                            cnt_next   = '0;
                            level_next = 1'b1;
                            rise_next  = 1'b1;
                        end else begin
                            state_next = RISE_CHK;
                            cnt_next   = CONF_ONE;
                        end
                    end
                end
                RISE_CHK: begin
                    if (sync2) begin
                        if (confirm_now) begin
                            state_next = STABLE_HI;
                            cnt_next   = '0;
                            level_next = 1'b1;
                            rise_next  = 1'b1;
                        end else begin
                            cnt_next = cnt_sat;
                        end
                    end else begin
                        state_next = STABLE_LO;
                        cnt_next   = '0;
                        glitch_evt = 1'b1;
                    end
                end
                STABLE_HI: begin
                    if (!sync2) begin
                        if (conf == CONF_ONE) begin
                            state_next = STABLE_LO;
                            cnt_next   = '0;
                            level_next = 1'b0;
                            fall_next  = 1'b1;
                        end else begin
                            state_next = FALL_CHK;
                            cnt_next   = CONF_ONE;
                        end
                    end
                end
                FALL_CHK: begin
                    if (!sync2) begin
                        if (confirm_now) begin
                            state_next = STABLE_LO;
                            cnt_next   = '0;
                            level_next = 1'b0;
                            fall_next  = 1'b1;
                        end else begin
                            cnt_next = cnt_sat;
                        end
                    end else begin
                        state_next = STABLE_HI;
                        cnt_next   = '0;
                        glitch_evt = 1'b1;
                    end
                end
                default: begin
                    state_next = INIT_STATE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // State, counter, filtered level and one-cycle edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT_STATE;
            cnt        <= '0;
            data_out   <= INIT_BIT;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            data_out   <= level_next;
            rise_pulse <= rise_next;
            fall_pulse <= fall_next;
        end
    end

`ifdef FILTER_GLITCH_CNT_EN
    // Saturating count of aborted checks; a clear in the same cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt <= '0;
        end else if (glitch_clr) begin
            glitch_cnt <= '0;
        end else if (glitch_evt && (glitch_cnt != {GCNT_W{1'b1}})) begin
            glitch_cnt <= glitch_cnt + {{(GCNT_W-1){1'b0}}, 1'b1};
        end
    end
`else
    logic unused_glitch;
    assign unused_glitch = glitch_clr | glitch_evt;
    assign glitch_cnt    = '0;
`endif

endmodule

// File: rtl/multi_debounce_filter.sv
// N-channel glitch filter: shared free-running prescaler produces a sample
// tick every 2**DIV_W clocks; each channel confirms level changes after
// max(cfg_confirm,1) consecutive agreeing samples.
// Optional feature macro: FILTER_GLITCH_CNT_EN (per-channel glitch counters).
module multi_debounce_filter
    import filter_sig_pkg::*;
#(
    parameter int CH_NUM     = 4,
    parameter int DIV_W      = 8,
    parameter int CONF_W     = 4,
    parameter int INIT_LEVEL = 0,
    parameter int GCNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CH_NUM-1:0]        data_in,
    input  logic [CONF_W-1:0]        cfg_confirm,
    output logic [CH_NUM-1:0]        data_out,
    output logic [CH_NUM-1:0]        rise_pulse,
    output logic [CH_NUM-1:0]        fall_pulse,
    input  logic                     glitch_clr,
    output logic [CH_NUM*GCNT_W-1:0] glitch_cnt
);

    logic [DIV_W-1:0]  presc;
    logic              tick;
    logic [CONF_W-1:0] conf_eff;

    // Per-channel FSM states, kept visible for probing.
    filt_state_e ch_state_unused [CH_NUM];

    // Free-running prescaler; wraps from all-ones to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else begin
            presc <= presc + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    assign tick     = &presc;
    assign conf_eff = (cfg_confirm == '0) ? CONF_W'(1) : cfg_confirm;

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        filter_channel #(
            .CONF_W     (CONF_W),
            .INIT_LEVEL (INIT_LEVEL),
            .GCNT_W     (GCNT_W)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .data_in    (data_in[i]),
            .tick       (tick),
            .conf       (conf_eff),
            .glitch_clr (glitch_clr),
            .data_out   (data_out[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i]),
            .glitch_cnt (glitch_cnt[i*GCNT_W +: GCNT_W]),
            .state      (ch_state_unused[i])
        );
    end

endmodule

// File: tb/tb_multi_debounce_filter.sv
// Testbench for multi_debounce_filter with a sample-run reference model.
// Optional feature macro: FILTER_GLITCH_CNT_EN (expects live glitch counters).
module tb_multi_debounce_filter;

    localparam int CH_NUM = 4;
    localparam int DIV_W  = 2;
    localparam int CONF_W = 4;
    localparam int INIT   = 0;
    localparam int GCNT_W = 16;
    localparam int P      = 1 << DIV_W;
    localparam int MAXC   = (1 << CONF_W) - 1;
    localparam int GMAX   = (1 << GCNT_W) - 1;

    logic                     clk;
    logic                     rst_n;
    logic [CH_NUM-1:0]        data_in;
    logic [CONF_W-1:0]        cfg_confirm;
    logic [CH_NUM-1:0]        data_out;
    logic [CH_NUM-1:0]        rise_pulse;
    logic [CH_NUM-1:0]        fall_pulse;
    logic                     glitch_clr;
    logic [CH_NUM*GCNT_W-1:0] glitch_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: filtered level plus length of the current run of
    // samples disagreeing with it; pin history delayed two clocks.
    int   cyc;
    logic m_level [CH_NUM];
    logic m_s1    [CH_NUM];
    logic m_s2    [CH_NUM];
    logic m_rise  [CH_NUM];
    logic m_fall  [CH_NUM];
    int   m_run   [CH_NUM];
    int   m_glitch[CH_NUM];

    multi_debounce_filter #(
        .CH_NUM     (CH_NUM),
        .DIV_W      (DIV_W),
        .CONF_W     (CONF_W),
        .INIT_LEVEL (INIT),
        .GCNT_W     (GCNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .cfg_confirm (cfg_confirm),
        .data_out    (data_out),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .glitch_clr  (glitch_clr),
        .glitch_cnt  (glitch_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        for (int c = 0; c < CH_NUM; c++) begin
            m_level[c]  = (INIT != 0);
            m_s1[c]     = (INIT != 0);
            m_s2[c]     = (INIT != 0);
            m_rise[c]   = 1'b0;
            m_fall[c]   = 1'b0;
            m_run[c]    = 0;
            m_glitch[c] = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [CH_NUM-1:0]        e_out;
        logic [CH_NUM-1:0]        e_rise;
        logic [CH_NUM-1:0]        e_fall;
        logic [CH_NUM*GCNT_W-1:0] e_gl;
        e_gl = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            e_out[c]  = m_level[c];
            e_rise[c] = m_rise[c];
            e_fall[c] = m_fall[c];
`ifdef FILTER_GLITCH_CNT_EN
            e_gl[c*GCNT_W +: GCNT_W] = GCNT_W'(m_glitch[c]);
`endif
        end
        check({tag, "_data_out"}, 64'(data_out), 64'(e_out));
        check({tag, "_rise"}, 64'(rise_pulse), 64'(e_rise));
        check({tag, "_fall"}, 64'(fall_pulse), 64'(e_fall));
        check({tag, "_glitch"}, 64'(glitch_cnt), 64'(e_gl));
    endtask

    // Advance model and DUT by one clock, then compare.
    task automatic step(input string tag);
        logic tk;
        logic s;
        logic evt;
        int   conf;
        tk   = ((cyc % P) == (P - 1));
        conf = (cfg_confirm == 0) ? 1 : int'(cfg_confirm);
        for (int c = 0; c < CH_NUM; c++) begin
            m_rise[c] = 1'b0;
            m_fall[c] = 1'b0;
            evt = 1'b0;
            if (tk) begin
                s = m_s2[c];
                if (s != m_level[c]) begin
                    m_run[c] = (m_run[c] + 1 > MAXC) ? MAXC : m_run[c] + 1;
                    if (m_run[c] >= conf) begin
                        m_level[c] = s;
                        m_run[c]   = 0;
                        if (s) m_rise[c] = 1'b1;
                        else   m_fall[c] = 1'b1;
                    end
                end else begin
                    if (m_run[c] > 0) evt = 1'b1;
                    m_run[c] = 0;
                end
            end
            if (glitch_clr)                      m_glitch[c] = 0;
            else if (evt && m_glitch[c] < GMAX)  m_glitch[c] = m_glitch[c] + 1;
            m_s2[c] = m_s1[c];
            m_s1[c] = data_in[c];
        end
        cyc++;
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    function automatic logic abort_next(input int c);
        return ((cyc % P) == (P - 1)) && (m_s2[c] == m_level[c]) && (m_run[c] > 0);
    endfunction

    initial begin
        int  lat;
        bit  hit;
        data_in     = '0;
        cfg_confirm = 4'd3;
        glitch_clr  = 1'b0;
        rst_n       = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all("reset");
        rst_n = 1'b1;

        // 1: quiet inputs for 10 ticks
        repeat (10 * P) step("t1");
        check("t1_out_low", 64'(data_out), 64'(0));
        check("t1_glitch_zero", 64'(glitch_cnt), 64'(0));

        // 2: ch0 held high, confirm=3; latency within 2 + P + 2P clocks
        data_in[0] = 1'b1;
        lat = 0;
        hit = 1'b0;
        for (int k = 1; k <= 20 && !hit; k++) begin
            step("t2");
            if (data_out[0]) begin
                lat = k;
                hit = 1'b1;
            end
        end
        check("t2_rise_seen", 64'(hit), 64'(1));
        check("t2_latency_ok", 64'((lat >= 3 + 2 * P) && (lat <= 2 + P + 2 * P)), 64'(1));

        // 3: ch1 high for two ticks, then low -> aborted rise
        data_in[1] = 1'b1;
        repeat (2 * P) step("t3");
        data_in[1] = 1'b0;
        repeat (3 * P) step("t3");
        check("t3_ch1_low", 64'(data_out[1]), 64'(0));
`ifdef FILTER_GLITCH_CNT_EN
        check("t3_ch1_glitch", 64'(glitch_cnt[GCNT_W +: GCNT_W]), 64'(1));
`else
        check("t3_ch1_glitch", 64'(glitch_cnt[GCNT_W +: GCNT_W]), 64'(0));
`endif

        // 4: confirm=0 acts as 1; ch2 toggles every tick
        cfg_confirm = '0;
        for (int k = 0; k < 10; k++) begin
            data_in[2] = ~data_in[2];
            repeat (P) step("t4");
        end
        check("t4_ch2_no_glitch", 64'(glitch_cnt[2*GCNT_W +: GCNT_W]), 64'(0));

        // 5: ch3 high, then reset during FALL_CHK with cnt=1
        data_in     = 4'b1000;
        cfg_confirm = 4'd2;
        repeat (4 * P) step("t5");
        data_in[3] = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            step("t5");
            if (m_level[3] && m_run[3] == 1) hit = 1'b1;
        end
        check("t5_reached_fallchk", 64'(hit), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("t5_async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 6: glitch_clr coincides with ch0 abort
        cfg_confirm = 4'd3;
        repeat (2 * P) step("t6");
        data_in[0] = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            step("t6");
            if (m_run[0] == 1) hit = 1'b1;
        end
        check("t6_reached_risechk", 64'(hit), 64'(1));
        data_in[0] = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            if (abort_next(0)) begin
                glitch_clr = 1'b1;
                hit = 1'b1;
            end
            step("t6");
            glitch_clr = 1'b0;
        end
        check("t6_abort_found", 64'(hit), 64'(1));
        check("t6_clr_wins", 64'(glitch_cnt[GCNT_W-1:0]), 64'(0));

        // Random phase: sparse pin changes, occasional config and clears
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                int ch;
                ch = int'($urandom_range(0, CH_NUM - 1));
                data_in[ch] = ~data_in[ch];
            end
            if ($urandom_range(0, 49) == 0) cfg_confirm = CONF_W'($urandom_range(0, 5));
            glitch_clr = ($urandom_range(0, 39) == 0);
            step("rand");
        end
        glitch_clr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
